// File: rtl/uart_rx_core.sv
// UART receiver: two-flop input synchronizer, 16x oversampling from a run-time divisor,
// 7/8 data bits with optional odd/even parity, and ready/parity/framing/overrun flags.
module uart_rx_core (
    input  logic        Clk,
    input  logic        sync_rst,
    input  logic        rx,
    input  logic [15:0] baud_div,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic        rx_read,
    output logic [7:0]  rx_data,
    output logic        rx_rdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_reg, state_next;
    logic        rx_meta_reg, rx_s_reg;
    logic [15:0] div_cnt_reg;
    logic [3:0]  tcnt_reg;
    logic [2:0]  bcnt_reg;
    logic [7:0]  shift_reg;
    logic        par_err_reg;
    logic [7:0]  rx_data_reg;
    logic        rx_rdy_reg, perr_reg, ferr_reg, ovf_reg;

    logic        tick, mid_tick, end_tick, last_bit;
    logic        go_start, sample_bit, sample_par, complete;
    logic [7:0]  data_word;
    logic        par_exp;

    assign tick      = (div_cnt_reg == baud_div);
    assign mid_tick  = tick && (tcnt_reg == 4'd7);
    assign end_tick  = tick && (tcnt_reg == 4'd15);
    assign last_bit  = (bcnt_reg == (eight ? 3'd7 : 3'd6));
    // In 7-bit mode bit 7 of the capture register is never written this frame, so mask it.
    assign data_word = {eight & shift_reg[7], shift_reg[6:0]};
    assign par_exp   = (^data_word) ^ ohel;

    always_ff @(posedge Clk) begin
        if (sync_rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (sync_rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        go_start   = 1'b0;
        sample_bit = 1'b0;
        sample_par = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next = START;
                    go_start   = 1'b1;
                end
            end
            START: begin
                if (mid_tick)
                    state_next = rx_s_reg ? IDLE : DATA;
            end
            DATA: begin
                if (end_tick) begin
                    sample_bit = 1'b1;
                    if (last_bit)
                        state_next = pen ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (end_tick) begin
                    sample_par = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (end_tick) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (sync_rst || go_start || tick)
            div_cnt_reg <= 16'd0;
        else
            div_cnt_reg <= div_cnt_reg + 16'd1;
    end

    // tcnt restarts at the start-bit centre so later samples land on bit centres.
    always_ff @(posedge Clk) begin
        if (sync_rst || go_start)
            tcnt_reg <= 4'd0;
        else if (tick) begin
            if (state_reg == START && tcnt_reg == 4'd7)
                tcnt_reg <= 4'd0;
            else
                tcnt_reg <= tcnt_reg + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (sync_rst || go_start)
            bcnt_reg <= 3'd0;
        else if (sample_bit)
            bcnt_reg <= bcnt_reg + 3'd1;
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_capture
        always_ff @(posedge Clk) begin
            if (sync_rst || go_start)
                shift_reg[gi] <= 1'b0;
            else if (sample_bit && bcnt_reg == 3'(gi))
                shift_reg[gi] <= rx_s_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (sync_rst || go_start)
            par_err_reg <= 1'b0;
        else if (sample_par)
            par_err_reg <= (rx_s_reg != par_exp);
    end

    // Completion takes priority over a simultaneous read.
    always_ff @(posedge Clk) begin
        if (sync_rst) begin
            rx_data_reg <= 8'h00;
            rx_rdy_reg  <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else if (complete) begin
            rx_data_reg <= data_word;
            rx_rdy_reg  <= 1'b1;
            perr_reg    <= pen & par_err_reg;
            ferr_reg    <= ~rx_s_reg;
            ovf_reg     <= rx_rdy_reg & ~rx_read;
        end else if (rx_read) begin
            rx_rdy_reg  <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end
    end

    assign rx_data = rx_data_reg;
    assign rx_rdy  = rx_rdy_reg;
    assign perr    = perr_reg;
    assign ferr    = ferr_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: bit-level frame driver, expected-result queue,
// and latency measurement from start-bit edge to rx_rdy rise.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        rx;
    logic [15:0] baud_div;
    logic        eight, pen, ohel, rx_read;
    logic [7:0]  rx_data;
    logic        rx_rdy, perr, ferr, ovf;

    uart_rx_core dut (
        .Clk      (clk),
        .sync_rst (sync_rst),
        .rx       (rx),
        .baud_div (baud_div),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .rx_read  (rx_read),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .perr     (perr),
        .ferr     (ferr),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   start_cyc = 0;
    logic rdy_prev = 1'b0;
    bit   rdy_model = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_rdy && !rdy_prev)
            rise_cyc <= cyc;
        rdy_prev <= rx_rdy;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one frame; read_at_done pulses rx_read on the completion clock (baud_div=0 only).
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                              input bit read_at_done);
        int   bitper;
        int   nb;
        exp_t e;
        bitper = 16 * (int'(baud_div) + 1);
        nb     = eight ? 8 : 7;
        e.data = eight ? d : {1'b0, d[6:0]};
        e.perr = pen && (par_bit != ((^e.data) ^ ohel));
        e.ferr = !stop_bit;
        e.ovf  = rdy_model && !read_at_done;
        sb.push_back(e);
        rdy_model = 1'b1;
        @(posedge clk);
        #1;
        rx = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < nb; i++) begin
            wait_clks(bitper);
            rx = d[i];
        end
        if (pen) begin
            wait_clks(bitper);
            rx = par_bit;
        end
        wait_clks(bitper);
        rx = stop_bit;
        if (read_at_done) begin
            wait_clks(10);
            rx_read = 1'b1;
            wait_clks(1);
            rx_read = 1'b0;
            wait_clks(bitper - 11);
        end else begin
            wait_clks(bitper);
        end
        rx = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            $display("[TB] %s: rx_data=%h rdy=%b perr=%b ferr=%b ovf=%b (exp %h %b %b %b)",
                     tag, rx_data, rx_rdy, perr, ferr, ovf, e.data, e.perr, e.ferr, e.ovf);
            chk({tag, "_data"}, 32'(rx_data), 32'(e.data));
            chk({tag, "_rdy"},  32'(rx_rdy),  32'd1);
            chk({tag, "_perr"}, 32'(perr),    32'(e.perr));
            chk({tag, "_ferr"}, 32'(ferr),    32'(e.ferr));
            chk({tag, "_ovf"},  32'(ovf),     32'(e.ovf));
        end
    endtask

    task automatic do_read(input string tag, input logic [7:0] held);
        rx_read = 1'b1;
        wait_clks(1);
        rx_read = 1'b0;
        rdy_model = 1'b0;
        $display("[TB] %s: read, rx_rdy=%b rx_data=%h", tag, rx_rdy, rx_data);
        chk({tag, "_rdy_clr"}, 32'(rx_rdy), 32'd0);
        chk({tag, "_ovf_clr"}, 32'(ovf), 32'd0);
        chk({tag, "_held"}, 32'(rx_data), 32'(held));
    endtask

    task automatic chk_all_zero(input string tag);
        $display("[TB] %s: rx_data=%h rdy=%b perr=%b ferr=%b ovf=%b",
                 tag, rx_data, rx_rdy, perr, ferr, ovf);
        chk({tag, "_data"}, 32'(rx_data), 32'h00);
        chk({tag, "_flags"}, 32'({rx_rdy, perr, ferr, ovf}), 32'h0);
    endtask

    initial begin
        int lat;
        sync_rst = 1'b1;
        rx       = 1'b1;
        rx_read  = 1'b0;
        baud_div = 16'd0;
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;
        wait_clks(3);
        sync_rst = 1'b0;
        chk_all_zero("reset");
        wait_clks(5);

        // 8N1 baseline with latency measurement
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check_frame("8n1_a5");
        lat = rise_cyc - start_cyc;
        $display("[TB] 8n1_a5 latency=%0d clocks", lat);
        chk("lat_div0", 32'(lat >= 153 && lat <= 157), 32'd1);
        do_read("8n1_a5", 8'hA5);
        wait_clks(20);

        // Leave a character pending, then reset in the middle of the next frame
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_frame("pending_5a");
        rx = 1'b0;
        wait_clks(40);
        sync_rst = 1'b1;
        wait_clks(3);
        chk_all_zero("midframe_reset");
        sync_rst = 1'b0;
        rx = 1'b1;
        rdy_model = 1'b0;
        wait_clks(200);
        chk("post_reset_idle_rdy", 32'(rx_rdy), 32'd0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        check_frame("post_reset_c3");
        do_read("post_reset_c3", 8'hC3);
        wait_clks(20);

        // 7-bit odd parity
        eight = 1'b0;
        pen   = 1'b1;
        ohel  = 1'b1;
        send_frame(8'h41, 1'b1, 1'b1, 1'b0);
        check_frame("7o1_good");
        do_read("7o1_good", 8'h41);
        wait_clks(20);
        send_frame(8'h41, 1'b0, 1'b1, 1'b0);
        check_frame("7o1_bad");
        do_read("7o1_bad", 8'h41);
        wait_clks(20);
        // 7-bit even parity, high data bit of the byte must be dropped
        ohel = 1'b0;
        send_frame(8'hB6, 1'b1, 1'b1, 1'b0);
        check_frame("7e1_b6");
        do_read("7e1_b6", 8'h36);
        wait_clks(20);

        // Framing error
        eight = 1'b1;
        pen   = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_frame("ferr_3c");
        wait_clks(30);
        do_read("ferr_3c", 8'h3C);
        wait_clks(20);

        // Short low glitch is rejected as a false start
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(40);
        $display("[TB] glitch: rx_rdy=%b", rx_rdy);
        chk("glitch_no_rdy", 32'(rx_rdy), 32'd0);

        // Overrun, then read colliding with completion
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        check_frame("ovr_11");
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check_frame("ovr_22");
        send_frame(8'h33, 1'b0, 1'b1, 1'b1);
        check_frame("collide_33");
        do_read("collide_33", 8'h33);
        wait_clks(20);

        // Divisor of 3: four times the bit period
        baud_div = 16'd3;
        wait_clks(10);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        check_frame("div3_ff");
        lat = rise_cyc - start_cyc;
        $display("[TB] div3_ff latency=%0d clocks", lat);
        chk("lat_div3", 32'(lat >= 600 && lat <= 630), 32'd1);
        do_read("div3_ff", 8'hFF);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
